// File: rtl/wb_burst_master.sv
// Wishbone burst write master: copies a block of words from a local read
// port onto Wishbone as single-word write cycles, with an optional watchdog.
//
// Ports:
//   Clock, Reset (async, active low)
//   iStart, iBurstLen, iInitialReadAddr, iWriteAddr, iWriteIncr : burst request (sampled in IDLE)
//   oReadAddress / iReadData : local read port (data used combinationally as DAT_O)
//   STB_O, CYC_O, WE_O, ADR_O, DAT_O, ACK_I, ERR_I : Wishbone master side
//   oBusy, oDone, oError, oCount : status
module wb_burst_master #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic [LEN_W-1:0] iBurstLen,
    input  logic [WIDTH-1:0] iInitialReadAddr,
    input  logic [WIDTH-1:0] iWriteAddr,
    input  logic             iWriteIncr,
    output logic [WIDTH-1:0] oReadAddress,
    input  logic [WIDTH-1:0] iReadData,
    output logic             STB_O,
    output logic             CYC_O,
    output logic             WE_O,
    input  logic             ACK_I,
    input  logic             ERR_I,
    output logic [WIDTH-1:0] DAT_O,
    output logic [WIDTH-1:0] ADR_O,
    output logic             oBusy,
    output logic             oDone,
    output logic             oError,
    output logic [LEN_W-1:0] oCount
);

    localparam int unsigned WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          WD_EN = (TIMEOUT != 0);
    // Watchdog value at which the next missed cycle is the TIMEOUT-th one
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_XFER   = 2'd1,
        S_FINISH = 2'd2,
        S_ABORT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [WIDTH-1:0]   raddr_q, raddr_d;
    logic [WIDTH-1:0]   waddr_q, waddr_d;
    logic               incr_q, incr_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               stb_q, stb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [LEN_W-1:0]   count_inc;

    assign count_inc = count_q + LEN_W'(1);

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        incr_d  = incr_q;
        wdog_d  = wdog_q;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    count_d = '0;
                    len_d   = iBurstLen;
                    raddr_d = iInitialReadAddr;
                    waddr_d = iWriteAddr;
                    incr_d  = iWriteIncr;
                    wdog_d  = '0;
                    state_d = (iBurstLen != '0) ? S_XFER : S_FINISH;
                end
            end
            S_XFER: begin
                if (ERR_I) begin
                    // Errored word is neither counted nor advanced past
                    state_d = S_ABORT;
                end else if (ACK_I) begin
                    count_d = count_inc;
                    raddr_d = raddr_q + WIDTH'(1);
                    if (incr_q) begin
                        waddr_d = waddr_q + WIDTH'(1);
                    end
                    wdog_d = '0;
                    if (count_inc == len_q) begin
                        state_d = S_FINISH;
                    end
                end else begin
                    if (wdog_q != WD_MAX) begin
                        wdog_d = wdog_q + WD_W'(1);
                    end
                    if (WD_EN && (wdog_q >= WD_LAST)) begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of the next state
        stb_d  = (state_d == S_XFER);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
        err_d  = (state_d == S_ABORT);
    end

    // State and output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            len_q   <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            incr_q  <= 1'b0;
            wdog_q  <= '0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            incr_q  <= incr_d;
            wdog_q  <= wdog_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign STB_O        = stb_q;
    assign CYC_O        = stb_q;
    assign WE_O         = stb_q;
    assign DAT_O        = iReadData;
    assign ADR_O        = waddr_q;
    assign oReadAddress = raddr_q;
    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oError       = err_q;
    assign oCount       = count_q;

endmodule
